// File: rtl/multi_input_conditioner_pkg.sv
// Shared defaults and a parameter sanity helper for the multi-channel input conditioner.
package multi_input_conditioner_pkg;

    localparam int unsigned DefChannels     = 4;
    localparam int unsigned DefSyncStages   = 2;
    localparam int unsigned DefCounterWidth = 3;
    localparam int unsigned DefWaitTime     = 3;

    // Debounce target must fit the counter; a single flop is not a synchroniser.
    function automatic bit cond_params_ok(int unsigned sync_stages,
                                          int unsigned counter_width,
                                          int unsigned wait_time);
        return (sync_stages >= 2) && (64'(wait_time) < (64'd1 << counter_width));
    endfunction

endpackage

// File: rtl/multi_input_conditioner_channel.sv
// One conditioner channel: synchroniser, polarity invert, debounce, edge pulses and
// sticky edge-capture flags.
module multi_input_conditioner_channel
    import multi_input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DefSyncStages,
    parameter int unsigned COUNTER_WIDTH = DefCounterWidth,
    parameter int unsigned WAIT_TIME     = DefWaitTime
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisysignal,
    input  logic invert,
    input  logic clearevents,
    output logic conditioned,
    output logic positiveedge,
    output logic negativeedge,
    output logic risecaught,
    output logic fallcaught
);

    if (!cond_params_ok(SYNC_STAGES, COUNTER_WIDTH, WAIT_TIME)) begin : g_bad_params
        $error("conditioner: need SYNC_STAGES >= 2 and WAIT_TIME < 2**COUNTER_WIDTH");
    end

    logic [SYNC_STAGES-1:0]   r_sync;
    logic [SYNC_STAGES-1:0]   r_armed;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic                     r_cond;
    logic                     r_pos;
    logic                     r_neg;
    logic                     r_rise;
    logic                     r_fall;

    logic w_p;
    logic w_mismatch;
    logic w_fire;

    assign w_p        = r_sync[SYNC_STAGES-1] ^ invert;
    // Sync contents are stale until refilled after reset; debounce waits for them.
    assign w_mismatch = r_armed[SYNC_STAGES-1] && (w_p != r_cond);
    assign w_fire     = w_mismatch && (r_cnt == COUNTER_WIDTH'(WAIT_TIME));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_armed <= '0;
            r_cnt   <= '0;
            r_cond  <= 1'b0;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], noisysignal};
            r_armed <= {r_armed[SYNC_STAGES-2:0], 1'b1};
            r_cnt   <= (w_mismatch && !w_fire) ? r_cnt + 1'b1 : '0;
            if (w_fire) begin
                r_cond <= w_p;
            end
            r_pos  <= w_fire & w_p;
            r_neg  <= w_fire & ~w_p;
            // A pulse coinciding with a clear keeps the flag set.
            r_rise <= r_pos | (r_rise & ~clearevents);
            r_fall <= r_neg | (r_fall & ~clearevents);
        end
    end

    assign conditioned  = r_cond;
    assign positiveedge = r_pos;
    assign negativeedge = r_neg;
    assign risecaught   = r_rise;
    assign fallcaught   = r_fall;

endmodule

// File: rtl/multi_input_conditioner.sv
// N-channel input conditioner: per-channel instances plus the anyevent reduction.
module multi_input_conditioner
    import multi_input_conditioner_pkg::*;
#(
    parameter int unsigned CHANNELS      = DefChannels,
    parameter int unsigned SYNC_STAGES   = DefSyncStages,
    parameter int unsigned COUNTER_WIDTH = DefCounterWidth,
    parameter int unsigned WAIT_TIME     = DefWaitTime
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisysignal,
    input  logic [CHANNELS-1:0] invert,
    input  logic [CHANNELS-1:0] clearevents,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] risecaught,
    output logic [CHANNELS-1:0] fallcaught,
    output logic                anyevent
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        multi_input_conditioner_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .COUNTER_WIDTH(COUNTER_WIDTH),
            .WAIT_TIME    (WAIT_TIME)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .noisysignal (noisysignal[g]),
            .invert      (invert[g]),
            .clearevents (clearevents[g]),
            .conditioned (conditioned[g]),
            .positiveedge(positiveedge[g]),
            .negativeedge(negativeedge[g]),
            .risecaught  (risecaught[g]),
            .fallcaught  (fallcaught[g])
        );
    end

    assign anyevent = |(risecaught | fallcaught);

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Directed bench for multi_input_conditioner at default parameters, 20 ns clock.
module tb_multi_input_conditioner;
    import multi_input_conditioner_pkg::*;

    localparam int unsigned Ch = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [Ch-1:0] noisy;
    logic [Ch-1:0] inv;
    logic [Ch-1:0] clr;
    logic [Ch-1:0] cond;
    logic [Ch-1:0] pos;
    logic [Ch-1:0] neg;
    logic [Ch-1:0] rise;
    logic [Ch-1:0] fall;
    logic          any;

    int total = 0;
    int bad   = 0;
    int pos_cnt [Ch] = '{0, 0, 0, 0};
    int neg_cnt [Ch] = '{0, 0, 0, 0};
    int both_cnt = 0;
    int p1, n1, n2, p3;

    always #10 clk = ~clk;

    multi_input_conditioner #(
        .CHANNELS     (Ch),
        .SYNC_STAGES  (DefSyncStages),
        .COUNTER_WIDTH(DefCounterWidth),
        .WAIT_TIME    (DefWaitTime)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .noisysignal (noisy),
        .invert      (inv),
        .clearevents (clr),
        .conditioned (cond),
        .positiveedge(pos),
        .negativeedge(neg),
        .risecaught  (rise),
        .fallcaught  (fall),
        .anyevent    (any)
    );

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < Ch; i++) begin
                if (pos[i]) pos_cnt[i]++;
                if (neg[i]) neg_cnt[i]++;
                if (pos[i] && neg[i]) both_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        noisy   = '0;
        inv     = '0;
        clr     = '0;

        // Reset held while pins toggle
        repeat (4) begin
            @(posedge clk);
            #1 noisy = ~noisy;
        end
        check("rst_cond", 32'(cond), 0);
        check("rst_pos", 32'(pos), 0);
        check("rst_neg", 32'(neg), 0);
        check("rst_rise", 32'(rise), 0);
        check("rst_fall", 32'(fall), 0);
        check("rst_any", 32'(any), 0);
        noisy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (8) tick();
        check("idle_cond", 32'(cond), 0);
        check("idle_any", 32'(any), 0);

        // Latency: ch0 rises on the sixth edge
        noisy[0] = 1'b1;
        repeat (5) tick();
        check("lat_e5_cond", 32'(cond), 0);
        check("lat_e5_pos", 32'(pos), 0);
        tick();
        check("lat_e6_cond", 32'(cond), 32'h1);
        check("lat_e6_pos", 32'(pos), 32'h1);
        tick();
        check("lat_e7_pos", 32'(pos), 0);
        check("lat_e7_rise", 32'(rise), 32'h1);
        check("lat_e7_any", 32'(any), 1);

        // Bounce on ch1 then settle high
        p1 = pos_cnt[1];
        repeat (6) #5 noisy[1] = ~noisy[1];
        noisy[1] = 1'b1;
        repeat (12) tick();
        check("bounce_cond", 32'(cond), 32'h3);
        check("bounce_pulses", 32'(pos_cnt[1] - p1), 1);

        // Three-cycle low glitch on ch1 is rejected
        n1 = neg_cnt[1];
        noisy[1] = 1'b0;
        repeat (3) tick();
        noisy[1] = 1'b1;
        repeat (10) tick();
        check("glitch_cond", 32'(cond), 32'h3);
        check("glitch_neg", 32'(neg_cnt[1] - n1), 0);
        check("glitch_pos", 32'(pos_cnt[1] - p1), 1);

        // ch2 high, then clear its rise flag
        noisy[2] = 1'b1;
        repeat (8) tick();
        check("ch2_up_cond", 32'(cond), 32'h7);
        clr = 4'b0100;
        tick();
        clr = '0;
        check("ch2_clr_rise", 32'(rise), 32'h3);

        // ch2 falls: one negativeedge, sticky fall until cleared
        n2 = neg_cnt[2];
        noisy[2] = 1'b0;
        repeat (5) tick();
        check("fall_e5_cond", 32'(cond), 32'h7);
        tick();
        check("fall_e6_neg", 32'(neg), 32'h4);
        check("fall_e6_cond", 32'(cond), 32'h3);
        tick();
        check("fall_sticky", 32'(fall), 32'h4);
        repeat (3) tick();
        check("fall_hold", 32'(fall), 32'h4);
        clr = 4'b0100;
        tick();
        clr = '0;
        check("fall_clr", 32'(fall), 0);
        check("fall_count", 32'(neg_cnt[2] - n2), 1);

        // Clear coinciding with a new pulse: set wins
        noisy[2] = 1'b1;
        repeat (5) tick();
        tick();
        check("coin_pos", 32'(pos), 32'h4);
        clr = 4'b0100;
        tick();
        clr = '0;
        check("coin_rise", 32'(rise), 32'h7);
        tick();
        check("coin_rise_hold", 32'(rise), 32'h7);

        // Async reset mid-debounce clears outputs without a clock edge
        noisy[0] = 1'b0;
        repeat (3) tick();
        #5 reset_n = 1'b0;
        #1;
        check("async_cond", 32'(cond), 0);
        check("async_rise", 32'(rise), 0);
        check("async_any", 32'(any), 0);

        // Invert on ch3 with pin low rises after release at normal latency
        inv   = 4'b1000;
        noisy = '0;
        repeat (2) @(posedge clk);
        p3 = pos_cnt[3];
        @(negedge clk) reset_n = 1'b1;
        repeat (5) tick();
        check("inv_e5_cond", 32'(cond), 0);
        tick();
        check("inv_e6_cond", 32'(cond), 32'h8);
        check("inv_e6_pos", 32'(pos), 32'h8);
        tick();
        check("inv_rise", 32'(rise), 32'h8);
        check("inv_any", 32'(any), 1);
        check("inv_count", 32'(pos_cnt[3] - p3), 1);

        // All channels switch together
        noisy = 4'b1111;
        repeat (5) tick();
        check("par_e5_cond", 32'(cond), 32'h8);
        tick();
        check("par_pos", 32'(pos), 32'h7);
        check("par_neg", 32'(neg), 32'h8);
        check("par_cond", 32'(cond), 32'h7);
        tick();
        check("par_fall", 32'(fall), 32'h8);
        check("never_both", 32'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
